// File: rtl/currctrl_regbank_pkg.sv
// Shared types and helpers for the current-controller register bank.
package currctrl_regbank_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;
  localparam int unsigned BYTE_W     = 8;

  // Even-parity bit for one byte: stored bit makes the 9-bit lane XOR to zero.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/currctrl_regbank_mem.sv
// True-dual-port byte-enabled array; a read returns the word as it was before
// any same-edge write from either port.
module currctrl_regbank_mem #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned LANE_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      a_en,
  input  logic                      a_we,
  input  logic [LANES-1:0]          a_be,
  input  logic [ADDR_W-1:0]         a_addr,
  input  logic [LANES*LANE_W-1:0]   a_wdata,
  output logic [LANES*LANE_W-1:0]   a_rdata,
  input  logic                      b_en,
  input  logic                      b_we,
  input  logic [LANES-1:0]          b_be,
  input  logic [ADDR_W-1:0]         b_addr,
  input  logic [LANES*LANE_W-1:0]   b_wdata,
  output logic [LANES*LANE_W-1:0]   b_rdata
);

  localparam int unsigned WORD_W = LANES * LANE_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Byte-lane writes from both ports; the top never issues two writes to one address.
  always_ff @(posedge clk) begin
    if (a_en && a_we) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (a_be[l]) mem[a_addr][l*LANE_W +: LANE_W] <= a_wdata[l*LANE_W +: LANE_W];
      end
    end
    if (b_en && b_we) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if (b_be[l]) mem[b_addr][l*LANE_W +: LANE_W] <= b_wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  // Registered reads; non-blocking update gives old data on a mixed-port hit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_en && !a_we) a_rdata <= mem[a_addr];
      if (b_en && !b_we) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/currctrl_regbank.sv
// Dual-port register bank (s1 = CPU, s2 = controller) with post-reset clear,
// s1-wins write arbitration and a 1- or 2-cycle read pipeline.
// Optional per-byte parity enabled by defining CURRCTRL_REGBANK_PARITY_EN.
module currctrl_regbank
  import currctrl_regbank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   s1_address,
  input  logic                s1_chipselect,
  input  logic                s1_read,
  input  logic                s1_write,
  input  logic [DATA_W/8-1:0] s1_byteenable,
  input  logic [DATA_W-1:0]   s1_writedata,
  output logic [DATA_W-1:0]   s1_readdata,
  output logic                s1_readdatavalid,
  output logic                s1_waitrequest,
  input  logic [ADDR_W-1:0]   s2_address,
  input  logic                s2_chipselect,
  input  logic                s2_read,
  input  logic                s2_write,
  input  logic [DATA_W/8-1:0] s2_byteenable,
  input  logic [DATA_W-1:0]   s2_writedata,
  output logic [DATA_W-1:0]   s2_readdata,
  output logic                s2_readdatavalid,
  output logic                s2_waitrequest,
  output logic                init_done
`ifdef CURRCTRL_REGBANK_PARITY_EN
  ,
  output logic                s1_parerr,
  output logic                s2_parerr
`endif
);

  localparam int unsigned LANES = DATA_W / BYTE_W;
`ifdef CURRCTRL_REGBANK_PARITY_EN
  localparam int unsigned LANE_W = BYTE_W + 1;
`else
  localparam int unsigned LANE_W = BYTE_W;
`endif
  localparam int unsigned STORE_W = LANES * LANE_W;

  // Reject unsupported configurations at elaboration.
  if ((DATA_W % BYTE_W) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_data_w
    $error("currctrl_regbank: DATA_W must be a multiple of 8 in 8..64");
  end
  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("currctrl_regbank: RD_LAT must be 1 or 2");
  end

  state_e            state;
  logic [ADDR_W-1:0] clr_ptr;

  logic run_c, s1_req_c, s2_req_c, collide_c;
  logic s1_v1_q, s2_v1_q;

  logic               mem_a_en_c, mem_a_we_c, mem_b_en_c;
  logic [LANES-1:0]   mem_a_be_c;
  logic [ADDR_W-1:0]  mem_a_addr_c;
  logic [STORE_W-1:0] mem_a_wdata_c;
  logic [STORE_W-1:0] s1_wstore_c, s2_wstore_c, mem_a_rdata, mem_b_rdata;
  logic [DATA_W-1:0]  s1_rdata_c, s2_rdata_c;

  assign run_c     = reset_n && (state == ST_RUN);
  assign s1_req_c  = s1_chipselect && (s1_read || s1_write);
  assign s2_req_c  = s2_chipselect && (s2_read || s2_write);
  assign collide_c = run_c && s1_req_c && s1_write && s2_req_c && s2_write &&
                     (s1_address == s2_address);

  assign s1_waitrequest = !run_c;
  assign s2_waitrequest = !run_c || collide_c;

  // Lane packing and unpacking between the bus and the stored word.
`ifdef CURRCTRL_REGBANK_PARITY_EN
  logic s1_perr_c, s2_perr_c;

  always_comb begin
    s1_wstore_c = '0;
    s2_wstore_c = '0;
    s1_rdata_c  = '0;
    s2_rdata_c  = '0;
    s1_perr_c   = 1'b0;
    s2_perr_c   = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      s1_wstore_c[l*LANE_W +: LANE_W] = {byte_parity(s1_writedata[l*BYTE_W +: BYTE_W]),
                                         s1_writedata[l*BYTE_W +: BYTE_W]};
      s2_wstore_c[l*LANE_W +: LANE_W] = {byte_parity(s2_writedata[l*BYTE_W +: BYTE_W]),
                                         s2_writedata[l*BYTE_W +: BYTE_W]};
      s1_rdata_c[l*BYTE_W +: BYTE_W]  = mem_a_rdata[l*LANE_W +: BYTE_W];
      s2_rdata_c[l*BYTE_W +: BYTE_W]  = mem_b_rdata[l*LANE_W +: BYTE_W];
      s1_perr_c = s1_perr_c | (^mem_a_rdata[l*LANE_W +: LANE_W]);
      s2_perr_c = s2_perr_c | (^mem_b_rdata[l*LANE_W +: LANE_W]);
    end
  end
`else
  assign s1_wstore_c = s1_writedata;
  assign s2_wstore_c = s2_writedata;
  assign s1_rdata_c  = mem_a_rdata;
  assign s2_rdata_c  = mem_b_rdata;
`endif

  // Port A carries the clear sweep during INIT and s1 during RUN.
  always_comb begin
    mem_a_en_c    = 1'b0;
    mem_a_we_c    = 1'b0;
    mem_a_be_c    = '0;
    mem_a_addr_c  = '0;
    mem_a_wdata_c = '0;
    if (reset_n) begin
      if (state == ST_INIT) begin
        mem_a_en_c   = 1'b1;
        mem_a_we_c   = 1'b1;
        mem_a_be_c   = '1;
        mem_a_addr_c = clr_ptr;
      end else begin
        mem_a_en_c    = s1_req_c;
        mem_a_we_c    = s1_write;
        mem_a_be_c    = s1_byteenable;
        mem_a_addr_c  = s1_address;
        mem_a_wdata_c = s1_wstore_c;
      end
    end
  end

  assign mem_b_en_c = run_c && s2_req_c && !collide_c;

  currctrl_regbank_mem #(
    .LANES  (LANES),
    .LANE_W (LANE_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .a_en    (mem_a_en_c),
    .a_we    (mem_a_we_c),
    .a_be    (mem_a_be_c),
    .a_addr  (mem_a_addr_c),
    .a_wdata (mem_a_wdata_c),
    .a_rdata (mem_a_rdata),
    .b_en    (mem_b_en_c),
    .b_we    (s2_write),
    .b_be    (s2_byteenable),
    .b_addr  (s2_address),
    .b_wdata (s2_wstore_c),
    .b_rdata (mem_b_rdata)
  );

  // INIT/RUN sequencer: one cleared word per cycle, then run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_INIT;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_INIT;
      endcase
    end
  end

  // First read-pipeline stage tracks reads accepted this edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_v1_q <= 1'b0;
      s2_v1_q <= 1'b0;
    end else begin
      s1_v1_q <= run_c && s1_req_c && !s1_write;
      s2_v1_q <= run_c && s2_req_c && !s2_write;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign s1_readdata      = s1_rdata_c;
    assign s2_readdata      = s2_rdata_c;
    assign s1_readdatavalid = s1_v1_q;
    assign s2_readdatavalid = s2_v1_q;
`ifdef CURRCTRL_REGBANK_PARITY_EN
    assign s1_parerr = s1_v1_q && s1_perr_c;
    assign s2_parerr = s2_v1_q && s2_perr_c;
`endif
  end else begin : g_lat2
    logic [DATA_W-1:0] s1_d2_q, s2_d2_q;
    logic              s1_v2_q, s2_v2_q;
`ifdef CURRCTRL_REGBANK_PARITY_EN
    logic              s1_p2_q, s2_p2_q;

    // Parity flag follows its data through the extra stage.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s1_p2_q <= 1'b0;
        s2_p2_q <= 1'b0;
      end else begin
        s1_p2_q <= s1_v1_q && s1_perr_c;
        s2_p2_q <= s2_v1_q && s2_perr_c;
      end
    end
    assign s1_parerr = s1_p2_q;
    assign s2_parerr = s2_p2_q;
`endif

    // Second read stage for RD_LAT=2.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s1_d2_q <= '0;
        s2_d2_q <= '0;
        s1_v2_q <= 1'b0;
        s2_v2_q <= 1'b0;
      end else begin
        s1_v2_q <= s1_v1_q;
        s2_v2_q <= s2_v1_q;
        if (s1_v1_q) s1_d2_q <= s1_rdata_c;
        if (s2_v1_q) s2_d2_q <= s2_rdata_c;
      end
    end
    assign s1_readdata      = s1_d2_q;
    assign s2_readdata      = s2_d2_q;
    assign s1_readdatavalid = s1_v2_q;
    assign s2_readdatavalid = s2_v2_q;
  end

endmodule

// File: tb/tb_currctrl_regbank.sv
// Directed bench for currctrl_regbank: dut uses RD_LAT=1, dut2 RD_LAT=2, shared inputs.
module tb_currctrl_regbank;

  logic        clk;
  logic        reset_n;
  logic [7:0]  s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write;
  logic        s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;

  logic [31:0] s1_readdata, s2_readdata, l2_s1_readdata, l2_s2_readdata;
  logic        s1_readdatavalid, s2_readdatavalid, l2_s1_readdatavalid, l2_s2_readdatavalid;
  logic        s1_waitrequest, s2_waitrequest, l2_s1_waitrequest, l2_s2_waitrequest;
  logic        init_done, l2_init_done;
`ifdef CURRCTRL_REGBANK_PARITY_EN
  logic        s1_parerr, s2_parerr, l2_s1_parerr, l2_s2_parerr;
`endif

  int tests = 0;
  int fails = 0;

  currctrl_regbank #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid), .s1_waitrequest(s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid), .s2_waitrequest(s2_waitrequest),
    .init_done(init_done)
`ifdef CURRCTRL_REGBANK_PARITY_EN
    , .s1_parerr(s1_parerr), .s2_parerr(s2_parerr)
`endif
  );

  currctrl_regbank #(.DATA_W(32), .ADDR_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(l2_s1_readdata), .s1_readdatavalid(l2_s1_readdatavalid), .s1_waitrequest(l2_s1_waitrequest),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(l2_s2_readdata), .s2_readdatavalid(l2_s2_readdatavalid), .s2_waitrequest(l2_s2_waitrequest),
    .init_done(l2_init_done)
`ifdef CURRCTRL_REGBANK_PARITY_EN
    , .s1_parerr(l2_s1_parerr), .s2_parerr(l2_s2_parerr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic drive_idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0; s1_address = '0; s1_byteenable = '0; s1_writedata = '0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0; s2_address = '0; s2_byteenable = '0; s2_writedata = '0;
  endtask

  task automatic s1_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = be;
    @(negedge clk);
    s1_chipselect = 0; s1_write = 0;
  endtask

  task automatic s2_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    s2_chipselect = 1; s2_write = 1; s2_address = a; s2_writedata = d; s2_byteenable = be;
    @(negedge clk);
    s2_chipselect = 0; s2_write = 0;
  endtask

  // Single s1 read; returns what dut shows one cycle after acceptance.
  task automatic s1_rd(input logic [7:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    s1_chipselect = 1; s1_read = 1; s1_address = a;
    @(negedge clk);
    s1_chipselect = 0; s1_read = 0;
    d = s1_readdata; v = s1_readdatavalid;
  endtask

  // Counts cycles from reset release until init_done, and how many had both waitrequests high.
  task automatic run_init(output int cyc, output int wr_hi);
    cyc = 0; wr_hi = 0;
    while (init_done !== 1'b1 && cyc < 1000) begin
      if (s1_waitrequest === 1'b1 && s2_waitrequest === 1'b1) wr_hi++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int cyc, wr_hi;
    reset_n = 0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (s1_readdatavalid !== 0 || s2_readdatavalid !== 0 || l2_s1_readdatavalid !== 0) begin
      fails++; $display("FAIL reset_valid: got %b%b%b, expected 000", s1_readdatavalid, s2_readdatavalid, l2_s1_readdatavalid);
    end
    tests++;
    if (s1_readdata !== 0 || s2_readdata !== 0 || l2_s1_readdata !== 0) begin
      fails++; $display("FAIL reset_data: got %h %h %h, expected 0", s1_readdata, s2_readdata, l2_s1_readdata);
    end
    tests++;
    if (s1_waitrequest !== 1 || s2_waitrequest !== 1 || init_done !== 0) begin
      fails++; $display("FAIL reset_wait: got wr=%b%b done=%b, expected wr=11 done=0", s1_waitrequest, s2_waitrequest, init_done);
    end
    reset_n = 1;
    run_init(cyc, wr_hi);
    tests++;
    if (cyc != 256 || wr_hi != 256) begin
      fails++; $display("FAIL init_len: got cyc=%0d wr_hi=%0d, expected 256 256", cyc, wr_hi);
    end
    tests++;
    if (s1_waitrequest !== 0 || s2_waitrequest !== 0 || l2_init_done !== 1) begin
      fails++; $display("FAIL run_wait: got wr=%b%b l2done=%b, expected 00 1", s1_waitrequest, s2_waitrequest, l2_init_done);
    end
  endtask

  // Back-to-back read of every address, one per cycle; all must read zero.
  task automatic test_clear_burst();
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if (s1_readdatavalid !== 1 || s1_readdata !== 32'h0) begin
          fails++; $display("FAIL clear_read[%0d]: got v=%b d=%h, expected v=1 d=0", i - 1, s1_readdatavalid, s1_readdata);
        end
      end
      if (i < 256) begin
        s1_chipselect = 1; s1_read = 1; s1_address = 8'(i);
      end else begin
        s1_chipselect = 0; s1_read = 0;
      end
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; logic v;
    s1_wr(8'd5, 32'hAABBCCDD, 4'hF);
    s2_wr(8'd5, 32'h11223344, 4'b0101);
    s1_rd(8'd5, d, v);
    tests++;
    if (v !== 1 || d !== 32'hAA22CC44) begin
      fails++; $display("FAIL byte_lanes: got v=%b d=%h, expected v=1 d=aa22cc44", v, d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic v;
    @(negedge clk);
    s1_chipselect = 1; s1_write = 1; s1_address = 8'd9; s1_writedata = 32'h1; s1_byteenable = 4'hF;
    s2_chipselect = 1; s2_write = 1; s2_address = 8'd9; s2_writedata = 32'h2; s2_byteenable = 4'hF;
    #1;
    tests++;
    if (s2_waitrequest !== 1 || s1_waitrequest !== 0) begin
      fails++; $display("FAIL collide_stall: got s1wr=%b s2wr=%b, expected 0 1", s1_waitrequest, s2_waitrequest);
    end
    @(negedge clk);
    s1_chipselect = 0; s1_write = 0;
    #1;
    tests++;
    if (s2_waitrequest !== 0) begin
      fails++; $display("FAIL collide_release: got s2wr=%b, expected 0", s2_waitrequest);
    end
    @(negedge clk);
    s2_chipselect = 0; s2_write = 0;
    s1_rd(8'd9, d, v);
    tests++;
    if (v !== 1 || d !== 32'h2) begin
      fails++; $display("FAIL collide_data: got v=%b d=%h, expected v=1 d=2", v, d);
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    s1_chipselect = 1; s1_write = 1; s1_address = 8'd20; s1_writedata = 32'h12345678; s1_byteenable = 4'hF;
    s2_chipselect = 1; s2_write = 1; s2_address = 8'd21; s2_writedata = 32'h9ABCDEF0; s2_byteenable = 4'hF;
    #1;
    tests++;
    if (s1_waitrequest !== 0 || s2_waitrequest !== 0) begin
      fails++; $display("FAIL dual_wait: got %b%b, expected 00", s1_waitrequest, s2_waitrequest);
    end
    @(negedge clk);
    s1_write = 0; s2_write = 0;
    s1_read = 1; s1_address = 8'd20;
    s2_read = 1; s2_address = 8'd21;
    @(negedge clk);
    drive_idle();
    tests++;
    if (s1_readdatavalid !== 1 || s1_readdata !== 32'h12345678) begin
      fails++; $display("FAIL dual_s1: got v=%b d=%h, expected v=1 d=12345678", s1_readdatavalid, s1_readdata);
    end
    tests++;
    if (s2_readdatavalid !== 1 || s2_readdata !== 32'h9ABCDEF0) begin
      fails++; $display("FAIL dual_s2: got v=%b d=%h, expected v=1 d=9abcdef0", s2_readdatavalid, s2_readdata);
    end
  endtask

  // Read and write asserted together on one port act as a write only.
  task automatic test_rw_same_port();
    logic [31:0] d; logic v;
    @(negedge clk);
    s1_chipselect = 1; s1_read = 1; s1_write = 1; s1_address = 8'd30; s1_writedata = 32'hCAFEF00D; s1_byteenable = 4'hF;
    @(negedge clk);
    drive_idle();
    tests++;
    if (s1_readdatavalid !== 0) begin
      fails++; $display("FAIL rw_novalid: got v=%b, expected 0", s1_readdatavalid);
    end
    s1_rd(8'd30, d, v);
    tests++;
    if (v !== 1 || d !== 32'hCAFEF00D) begin
      fails++; $display("FAIL rw_data: got v=%b d=%h, expected v=1 d=cafef00d", v, d);
    end
  endtask

  task automatic test_mixed_rw();
    logic [31:0] d; logic v;
    s1_wr(8'd3, 32'h7, 4'hF);
    @(negedge clk);
    s1_chipselect = 1; s1_read = 1; s1_address = 8'd3;
    s2_chipselect = 1; s2_write = 1; s2_address = 8'd3; s2_writedata = 32'h8; s2_byteenable = 4'hF;
    #1;
    tests++;
    if (s2_waitrequest !== 0) begin
      fails++; $display("FAIL mixed_wait: got s2wr=%b, expected 0", s2_waitrequest);
    end
    @(negedge clk);
    drive_idle();
    tests++;
    if (s1_readdatavalid !== 1 || s1_readdata !== 32'h7) begin
      fails++; $display("FAIL mixed_old_lat1: got v=%b d=%h, expected v=1 d=7", s1_readdatavalid, s1_readdata);
    end
    tests++;
    if (l2_s1_readdatavalid !== 0) begin
      fails++; $display("FAIL mixed_lat2_early: got v=%b, expected 0", l2_s1_readdatavalid);
    end
    @(negedge clk);
    tests++;
    if (l2_s1_readdatavalid !== 1 || l2_s1_readdata !== 32'h7 || s1_readdatavalid !== 0) begin
      fails++; $display("FAIL mixed_old_lat2: got v=%b d=%h v1=%b, expected v=1 d=7 v1=0", l2_s1_readdatavalid, l2_s1_readdata, s1_readdatavalid);
    end
    s1_rd(8'd3, d, v);
    tests++;
    if (v !== 1 || d !== 32'h8) begin
      fails++; $display("FAIL mixed_new: got v=%b d=%h, expected v=1 d=8", v, d);
    end
  endtask

  // Pipelined reads of known words on both latencies.
  task automatic test_back_to_back();
    logic [7:0]  addrs [4];
    logic [31:0] exp [4];
    addrs[0] = 8'd5;  exp[0] = 32'hAA22CC44;
    addrs[1] = 8'd9;  exp[1] = 32'h2;
    addrs[2] = 8'd3;  exp[2] = 32'h8;
    addrs[3] = 8'd30; exp[3] = 32'hCAFEF00D;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 1 && i <= 4) begin
        tests++;
        if (s1_readdatavalid !== 1 || s1_readdata !== exp[i-1]) begin
          fails++; $display("FAIL b2b_lat1[%0d]: got v=%b d=%h, expected v=1 d=%h", i - 1, s1_readdatavalid, s1_readdata, exp[i-1]);
        end
      end
      if (i >= 2) begin
        tests++;
        if (l2_s1_readdatavalid !== 1 || l2_s1_readdata !== exp[i-2]) begin
          fails++; $display("FAIL b2b_lat2[%0d]: got v=%b d=%h, expected v=1 d=%h", i - 2, l2_s1_readdatavalid, l2_s1_readdata, exp[i-2]);
        end
      end
      if (i < 4) begin
        s1_chipselect = 1; s1_read = 1; s1_address = addrs[i];
      end else begin
        s1_chipselect = 0; s1_read = 0;
      end
    end
  endtask

  task automatic test_midrun_reset();
    int cyc, wr_hi;
    logic [31:0] d; logic v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s1_chipselect = 1; s1_read = 1; s1_address = 8'(i);
      if (i == 3) reset_n = 0;
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      tests++;
      if (s1_readdatavalid !== 0 || l2_s1_readdatavalid !== 0 || l2_s1_readdata !== 0 || s1_readdata !== 0) begin
        fails++; $display("FAIL midreset_flush[%0d]: got v=%b%b d=%h %h, expected 00 0 0", j, s1_readdatavalid, l2_s1_readdatavalid, s1_readdata, l2_s1_readdata);
      end
      tests++;
      if (s1_waitrequest !== 1 || init_done !== 0) begin
        fails++; $display("FAIL midreset_state[%0d]: got wr=%b done=%b, expected 1 0", j, s1_waitrequest, init_done);
      end
    end
    drive_idle();
    reset_n = 1;
    run_init(cyc, wr_hi);
    tests++;
    if (cyc != 256 || wr_hi != 256) begin
      fails++; $display("FAIL midreset_init: got cyc=%0d wr_hi=%0d, expected 256 256", cyc, wr_hi);
    end
    s1_rd(8'd5, d, v);
    tests++;
    if (v !== 1 || d !== 32'h0) begin
      fails++; $display("FAIL midreset_cleared: got v=%b d=%h, expected v=1 d=0", v, d);
    end
  endtask

`ifdef CURRCTRL_REGBANK_PARITY_EN
  task automatic test_parity();
    logic [31:0] d; logic v;
    s1_wr(8'd4, 32'h0F0F0F0F, 4'hF);
    @(negedge clk);
    s1_chipselect = 1; s1_read = 1; s1_address = 8'd4;
    @(negedge clk);
    s1_chipselect = 0; s1_read = 0;
    tests++;
    if (s1_readdatavalid !== 1 || s1_parerr !== 0) begin
      fails++; $display("FAIL parity_clean: got v=%b perr=%b, expected 1 0", s1_readdatavalid, s1_parerr);
    end
    dut.u_mem.mem[4][0] = ~dut.u_mem.mem[4][0];
    @(negedge clk);
    s1_chipselect = 1; s1_read = 1; s1_address = 8'd4;
    @(negedge clk);
    s1_chipselect = 0; s1_read = 0;
    d = s1_readdata; v = s1_readdatavalid;
    tests++;
    if (v !== 1 || s1_parerr !== 1 || d !== 32'h0F0F0F0E) begin
      fails++; $display("FAIL parity_flip: got v=%b perr=%b d=%h, expected 1 1 0f0f0f0e", v, s1_parerr, d);
    end
  endtask
`endif

  initial begin
    clk = 0;
    reset_n = 0;
    drive_idle();
    test_reset();
    test_clear_burst();
    test_byte_lanes();
    test_collision();
    test_dual_write();
    test_rw_same_port();
    test_mixed_rw();
    test_back_to_back();
`ifdef CURRCTRL_REGBANK_PARITY_EN
    test_parity();
`endif
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/currctrl_regbank.md
CURRCTRL_REGBANK -- requirements
Module: currctrl_regbank

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits, a multiple of 8 in the range 8..64.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles, legal values 1 or 2.
REQ-004 SHALL have ports, each listed as name, direction, width, meaning:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous active-low reset.
- sN_address  in  ADDR_W  word address (N = 1 is the CPU port, N = 2 is the controller port; this applies to every sN_ port below).
- sN_chipselect  in  1  port select.
- sN_read  in  1  read request.
- sN_write  in  1  write request.
- sN_byteenable  in  DATA_W/8  byte-lane write enables.
- sN_writedata  in  DATA_W  write data.
- sN_readdata  out  DATA_W  read data.
- sN_readdatavalid  out  1  readdata qualifier.
- sN_waitrequest  out  1  stall; the command is not accepted while this is high.
- init_done  out  1  high once the post-reset clear has finished.

Function
REQ-010 A command on port N SHALL be accepted on a clk edge where sN_chipselect=1, (sN_read or sN_write)=1 and sN_waitrequest=0; the master SHALL hold the command stable while waitrequest is high.
REQ-011 A command with sN_read=1 and sN_write=1 together SHALL be treated as a write only.
REQ-012 An accepted write SHALL update only the byte lanes whose byteenable bit is 1, in the cycle of acceptance.
REQ-013 An accepted read SHALL return data with sN_readdatavalid high for exactly one cycle, RD_LAT cycles after acceptance; back-to-back reads SHALL pipeline at one per cycle.
REQ-014 The FSM SHALL have states INIT and RUN; reset SHALL enter INIT with clear pointer 0.
REQ-015 In INIT the block SHALL write zero to one word per cycle at the clear pointer, hold both waitrequests high, and move to RUN after word DEPTH-1 (DEPTH cycles in total).
REQ-016 init_done SHALL be 0 in INIT and 1 in RUN.
REQ-017 In RUN, if both ports present a write to the same address in the same cycle, s1 SHALL win, and s2_waitrequest SHALL be high for that cycle so that s2 completes on the next cycle (net result: s2's data is stored last).
REQ-018 In RUN, s1_waitrequest SHALL always be 0, and s2_waitrequest SHALL be 1 only in the collision case of REQ-017.
REQ-019 A read on one port in the same cycle as a write to the same address on the other port SHALL return the old data; a read on the same port cannot coincide with a write (REQ-011).
REQ-020 Writes to different addresses on both ports SHALL complete in the same cycle.

Reset
REQ-030 On reset_n=0 at a clk edge: sN_readdatavalid=0, sN_readdata=0, sN_waitrequest=1, init_done=0, and any read pipeline contents SHALL be discarded.
REQ-031 Reset asserted during INIT or RUN SHALL restart the clear from word 0.
REQ-032 Memory contents SHALL be undefined only until the clear completes.

Configuration
REQ-040 The macro CURRCTRL_REGBANK_PARITY_EN SHALL control parity protection.
REQ-041 With CURRCTRL_REGBANK_PARITY_EN defined: store one even-parity bit per byte, written with its byte (INIT writes parity 0), and add outputs s1_parerr and s2_parerr (1 bit each), high together with readdatavalid when any returned byte fails its parity check.
REQ-042 Without CURRCTRL_REGBANK_PARITY_EN: no parity storage, and the s1_parerr and s2_parerr ports are absent.

Structure
REQ-050 Package currctrl_regbank_pkg SHALL hold the FSM state enum, the RD_LAT legal-value constants, and a function computing byte parity.
REQ-051 Sub-module currctrl_regbank_mem SHALL implement the true-dual-port byte-enabled array with old-data mixed-port read; collision arbitration, the FSM and the read pipeline SHALL stay in the top level.
REQ-052 Illegal DATA_W or RD_LAT values SHALL cause an elaboration-time error.

Verification
REQ-060 Reset: release reset_n, ADDR_W=8 -> waitrequest high for 256 cycles, init_done rises on cycle 256, and a read of every address returns 0.
REQ-061 Byte lanes: s1 writes 0xAABBCCDD to address 5, then s2 writes 0x11223344 with byteenable 0b0101 -> read of address 5 returns 0xAA22CC44.
REQ-062 Collision: in the same cycle s1 writes 0x1 and s2 writes 0x2 to address 9 -> s2_waitrequest high for one cycle, and a subsequent read returns 0x2.
REQ-063 Mixed read/write: s1 reads address 3 (holding 0x7) while s2 writes 0x8 there -> s1 gets 0x7; with RD_LAT=2, readdatavalid appears 2 cycles after acceptance.
REQ-064 Mid-run reset: pulse reset_n during a read burst -> no readdatavalid is emitted, and INIT restarts at word 0.
REQ-065 Parity (macro defined): force a flipped stored bit at address 4, then read address 4 -> s1_parerr=1 together with readdatavalid.
